// File: rtl/jk_pkg.sv
// jk_pkg: opcode and FSM encodings shared by the jk/sr flip-flop command path.
package jk_pkg;
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_SET  = 2'b01,
    JK_CLR  = 2'b10,
    JK_TOG  = 2'b11
  } jk_op_e;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } jk_state_e;
  function automatic logic [1:0] jk_drive(jk_op_e op);
    return op == JK_SET ? 2'b10 : op == JK_CLR ? 2'b01 : op == JK_TOG ? 2'b11 : 2'b00;
  endfunction
endpackage

// File: rtl/jk_cmd_queue_if.sv
// jk_cmd_queue_if: valid/ready command channel into the j/k sequencer.
interface jk_cmd_queue_if;
  import jk_pkg::*;
  logic   cmd_valid;
  jk_op_e cmd_op;
  logic   cmd_ready;
  modport master (output cmd_valid, cmd_op, input cmd_ready);
  modport slave (input cmd_valid, cmd_op, output cmd_ready);
endinterface

// File: rtl/jk_cmd_fifo.sv
// jk_cmd_fifo: power-of-two circular buffer with occupancy count.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(pop_i);
      count_q <= count_q + (AW + 1)'(push_i) - (AW + 1)'(pop_i);
    end
  end
  assign dout_o = mem_q[rd_q];
  assign count_o = count_q;
  assign full_o = count_q == (AW + 1)'(DEPTH);
  assign empty_o = count_q == '0;
endmodule

// File: rtl/jk_cmd_queue.sv
// jk_cmd_queue: queues HOLD/SET/CLR/TOGGLE opcodes and issues each as a one-cycle j/k pulse,
// keeping a shadow of the downstream flip-flop state.
module jk_cmd_queue import jk_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int GAP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  jk_cmd_queue_if.slave          cmd,
  output logic                   j,
  output logic                   k,
  output logic                   issued,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   shadow_q,
  output logic                   shadow_known
);
  jk_state_e state_q, state_d;
  logic [3:0] gap_q, gap_d;
  jk_op_e op_q, head;
  logic [1:0] head_raw, jk_q;
  logic issued_q, sq_q, sq_d, sk_q, sk_d, full, empty, push, pop;
  jk_cmd_fifo #(.DEPTH(DEPTH), .W(2)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (cmd.cmd_op),
    .dout_o  (head_raw),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );
  assign head = jk_op_e'(head_raw);
  assign cmd.cmd_ready = ~full;
  assign push = cmd.cmd_valid & ~full;
  always_comb begin
    state_d = state_q;
    gap_d = gap_q;
    pop = 1'b0;
    unique case (state_q)
      ST_ISSUE: begin
        if (GAP > 0) begin
          state_d = ST_WAIT;
          gap_d = 4'(GAP - 1);
        end else begin
          pop = ~empty;
          state_d = empty ? ST_IDLE : ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (gap_q != '0) gap_d = gap_q - 4'd1;
        else begin
          pop = ~empty;
          state_d = empty ? ST_IDLE : ST_ISSUE;
        end
      end
      default: begin
        pop = ~empty;
        state_d = empty ? ST_IDLE : ST_ISSUE;
      end
    endcase
  end
  // shadow follows the op whose ISSUE cycle is ending; TOGGLE of an unknown q stays unknown
  always_comb begin
    sq_d = sq_q;
    sk_d = sk_q;
    if (state_q == ST_ISSUE) begin
      sq_d = op_q == JK_SET ? 1'b1 : op_q == JK_CLR ? 1'b0 : (op_q == JK_TOG && sk_q) ? ~sq_q : sq_q;
      sk_d = sk_q | op_q == JK_SET | op_q == JK_CLR;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gap_q <= '0;
      op_q <= JK_HOLD;
      jk_q <= 2'b00;
      issued_q <= 1'b0;
      sq_q <= 1'b0;
      sk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q <= gap_d;
      op_q <= pop ? head : op_q;
      jk_q <= pop ? jk_drive(head) : 2'b00;
      issued_q <= pop;
      sq_q <= sq_d;
      sk_q <= sk_d;
    end
  end
  assign {j, k} = jk_q;
  assign issued = issued_q;
  assign busy = state_q != ST_IDLE || !empty;
  assign shadow_q = sq_q;
  assign shadow_known = sk_q;
endmodule

// File: tb/tb_jk_cmd_queue.sv
// tb_jk_cmd_queue: table vectors, a GAP=0 burst and random traffic against a time-slot queue model.
module tb_jk_cmd_queue;
  import jk_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  jk_cmd_queue_if ifa ();
  jk_cmd_queue_if ifb ();
  logic ja, ka, ia, ba, sqa, ska, jb, kb, ib, bb, sqb, skb;
  logic [2:0] ca, cb;
  jk_cmd_queue #(.DEPTH(DEPTH), .GAP(1)) dut_a (
    .clk(clk), .rst(rst), .cmd(ifa), .j(ja), .k(ka), .issued(ia), .busy(ba),
    .count(ca), .shadow_q(sqa), .shadow_known(ska)
  );
  jk_cmd_queue #(.DEPTH(DEPTH), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .cmd(ifb), .j(jb), .k(kb), .issued(ib), .busy(bb),
    .count(cb), .shadow_q(sqb), .shadow_known(skb)
  );
  typedef struct {
    logic r, v;
    logic [1:0] op, jk;
    logic iss;
    int cnt;
    logic b, sq, sk, rdy;
  } vec_t;
  vec_t tbl [31];
  int checks = 0, failures = 0, t = 0;
  logic [1:0] mq [2][$];
  logic [1:0] pop_op [2], mjk [2];
  logic pv [2], miss [2], msq [2], msk [2];
  int nok [2];
  function automatic vec_t mk(logic r, logic v, logic [1:0] op, logic [1:0] jk, logic iss,
                              int cnt, logic b, logic sq, logic sk, logic rdy);
    vec_t x;
    x.r = r; x.v = v; x.op = op; x.jk = jk; x.iss = iss; x.cnt = cnt;
    x.b = b; x.sq = sq; x.sk = sk; x.rdy = rdy;
    return x;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, t, act, exp);
    end
  endtask
  task automatic model(input logic r, input logic v, input logic [1:0] op);
    for (int d = 0; d < 2; d++) begin
      int sz;
      sz = mq[d].size();
      if (r) begin
        mq[d].delete();
        pv[d] = 0; miss[d] = 0; mjk[d] = 2'b00; msq[d] = 0; msk[d] = 0; nok[d] = 0;
      end else begin
        if (pv[d]) begin
          if (pop_op[d] == 2'b01) begin msq[d] = 1; msk[d] = 1; end
          else if (pop_op[d] == 2'b10) begin msq[d] = 0; msk[d] = 1; end
          else if (pop_op[d] == 2'b11 && msk[d]) msq[d] = ~msq[d];
        end
        miss[d] = sz > 0 && t >= nok[d];
        pv[d] = miss[d];
        mjk[d] = 2'b00;
        if (miss[d]) begin
          pop_op[d] = mq[d].pop_front();
          nok[d] = t + (d == 0 ? 1 : 0) + 1;
          mjk[d] = {pop_op[d] == 2'b01 || pop_op[d] == 2'b11, pop_op[d] == 2'b10 || pop_op[d] == 2'b11};
        end
        if (v && sz < DEPTH) mq[d].push_back(op);
      end
    end
  endtask
  task automatic step(input logic r, input logic v, input logic [1:0] op);
    rst = r;
    ifa.cmd_valid = v; ifa.cmd_op = jk_op_e'(op);
    ifb.cmd_valid = v; ifb.cmd_op = jk_op_e'(op);
    @(posedge clk);
    t++;
    model(r, v, op);
    #1;
    chk("a_jk", {ja, ka}, mjk[0]);
    chk("a_issued", ia, miss[0]);
    chk("a_count", ca, mq[0].size());
    chk("a_ready", ifa.cmd_ready, mq[0].size() < DEPTH);
    chk("a_busy", ba, mq[0].size() > 0 || t < nok[0]);
    chk("a_shadow_q", sqa, msq[0]);
    chk("a_shadow_known", ska, msk[0]);
    chk("b_jk", {jb, kb}, mjk[1]);
    chk("b_issued", ib, miss[1]);
    chk("b_count", cb, mq[1].size());
    chk("b_ready", ifb.cmd_ready, mq[1].size() < DEPTH);
    chk("b_busy", bb, mq[1].size() > 0 || t < nok[1]);
    chk("b_shadow_q", sqb, msq[1]);
    chk("b_shadow_known", skb, msk[1]);
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      pv[d] = 0; miss[d] = 0; mjk[d] = 2'b00; msq[d] = 0; msk[d] = 0; nok[d] = 0; pop_op[d] = 2'b00;
    end
    ifa.cmd_valid = 0; ifa.cmd_op = JK_HOLD; ifb.cmd_valid = 0; ifb.cmd_op = JK_HOLD;
    //           r  v  op     jk    iss cnt b  sq sk rdy
    tbl[0]  = mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0, 1, 2'b01, 2'b00, 0, 1, 1, 0, 0, 1);
    tbl[2]  = mk(0, 0, 2'b00, 2'b10, 1, 0, 1, 0, 0, 1);
    tbl[3]  = mk(0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 1, 1);
    tbl[4]  = mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 1);
    tbl[5]  = mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(0, 1, 2'b11, 2'b00, 0, 1, 1, 0, 0, 1);
    tbl[7]  = mk(0, 1, 2'b01, 2'b11, 1, 1, 1, 0, 0, 1);
    tbl[8]  = mk(0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 1);
    tbl[9]  = mk(0, 0, 2'b00, 2'b10, 1, 0, 1, 0, 0, 1);
    tbl[10] = mk(0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 1, 1);
    tbl[11] = mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 1);
    tbl[12] = mk(0, 1, 2'b01, 2'b00, 0, 1, 1, 1, 1, 1);
    tbl[13] = mk(0, 1, 2'b10, 2'b10, 1, 1, 1, 1, 1, 1);
    tbl[14] = mk(0, 1, 2'b11, 2'b00, 0, 2, 1, 1, 1, 1);
    tbl[15] = mk(0, 1, 2'b01, 2'b01, 1, 2, 1, 1, 1, 1);
    tbl[16] = mk(0, 1, 2'b11, 2'b00, 0, 3, 1, 0, 1, 1);
    tbl[17] = mk(0, 1, 2'b00, 2'b11, 1, 3, 1, 0, 1, 1);
    tbl[18] = mk(1, 1, 2'b01, 2'b00, 0, 0, 0, 0, 0, 1);
    tbl[19] = mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
    tbl[20] = mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
    tbl[21] = mk(0, 1, 2'b11, 2'b00, 0, 1, 1, 0, 0, 1);
    tbl[22] = mk(0, 1, 2'b11, 2'b11, 1, 1, 1, 0, 0, 1);
    tbl[23] = mk(0, 1, 2'b11, 2'b00, 0, 2, 1, 0, 0, 1);
    tbl[24] = mk(0, 1, 2'b11, 2'b11, 1, 2, 1, 0, 0, 1);
    tbl[25] = mk(0, 1, 2'b11, 2'b00, 0, 3, 1, 0, 0, 1);
    tbl[26] = mk(0, 1, 2'b11, 2'b11, 1, 3, 1, 0, 0, 1);
    tbl[27] = mk(0, 1, 2'b11, 2'b00, 0, 4, 1, 0, 0, 0);
    tbl[28] = mk(0, 1, 2'b11, 2'b11, 1, 3, 1, 0, 0, 1);
    tbl[29] = mk(0, 1, 2'b11, 2'b00, 0, 4, 1, 0, 0, 0);
    tbl[30] = mk(0, 0, 2'b00, 2'b11, 1, 3, 1, 0, 0, 1);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].op);
      chk("tbl_jk", {ja, ka}, tbl[i].jk);
      chk("tbl_issued", ia, tbl[i].iss);
      chk("tbl_count", ca, tbl[i].cnt);
      chk("tbl_busy", ba, tbl[i].b);
      chk("tbl_shadow_q", sqa, tbl[i].sq);
      chk("tbl_shadow_known", ska, tbl[i].sk);
      chk("tbl_ready", ifa.cmd_ready, tbl[i].rdy);
    end
    step(1, 0, 2'b00);
    step(0, 1, 2'b01);
    step(0, 1, 2'b11);
    chk("g0_jk0", {jb, kb}, 2'b10);
    step(0, 1, 2'b11);
    chk("g0_jk1", {jb, kb}, 2'b11);
    chk("g0_sq0", sqb, 1);
    step(0, 1, 2'b10);
    chk("g0_jk2", {jb, kb}, 2'b11);
    chk("g0_sq1", sqb, 0);
    step(0, 0, 2'b00);
    chk("g0_jk3", {jb, kb}, 2'b01);
    chk("g0_sq2", sqb, 1);
    step(0, 0, 2'b00);
    chk("g0_sq3", sqb, 0);
    chk("g0_known", skb, 1);
    chk("g0_idle", bb, 0);
    repeat (3000) step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 2'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jk_cmd_queue.md
# jk_cmd_queue

Command sequencer that sits directly upstream of the team's `jk_flip_flop` and its `sr_flip_flop` wrapper, and drives their `j`/`k` inputs. It accepts opcodes (HOLD/SET/CLR/TOGGLE) over a valid/ready handshake and buffers them in a small FIFO. It issues each opcode as a one-cycle `j`/`k` pulse, with a programmable idle gap between pulses. It also keeps a shadow copy of the flip-flop state, so downstream logic can read it without tapping `q`.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries. Must be a power of two, 2..16.
- `GAP`, default 1: idle (HOLD) cycles inserted after each issued command. Range 0..15.

Ports:
- `clk`  in  1: single clock, rising edge. The downstream flip-flop uses the same clock.
- `rst`  in  1: synchronous, active-high reset. Sampled only on the rising edge of `clk`.
- `cmd_valid`  in  1: a command is offered.
- `cmd_op`  in  2: opcode. 00 HOLD, 01 SET, 10 CLR, 11 TOGGLE.
- `cmd_ready`  out  1: the FIFO can accept a command this cycle.
- `j`  out  1: to flip-flop `j` (or `s` on the SR wrapper). Registered.
- `k`  out  1: to flip-flop `k` (or `r` on the SR wrapper). Registered.
- `issued`  out  1: one-cycle pulse, coincident with the `j`/`k` drive of each command.
- `busy`  out  1: the block is not IDLE, or the FIFO is not empty.
- `count`  out  $clog2(DEPTH)+1: FIFO occupancy.
- `shadow_q`  out  1: modelled flip-flop output after the most recently issued command has been sampled.
- `shadow_known`  out  1: `shadow_q` is valid. Reset clears it; the first issued SET or CLR sets it.

## Operation
Handshake:
- A push occurs when `cmd_valid & cmd_ready` at a rising edge.
- `cmd_ready = (count != DEPTH)`. It is a function of registered state only; there is no combinational path from a pop.
- `cmd_valid` may drop without a transfer. `cmd_op` is only sampled on a push.

Opcode to `j`/`k` mapping:
- HOLD gives 0/0. It still occupies an issue slot and the gap.
- SET gives 1/0. CLR gives 0/1. TOGGLE gives 1/1.

State machine:
- IDLE: `j=k=0`. If the FIFO is non-empty, pop the head, go to ISSUE and drive that opcode's `j`/`k` from the next cycle.
- ISSUE: lasts exactly one cycle. `j`/`k` follow the popped opcode and `issued=1`. Next state:
  - `GAP>0`: go to WAIT, with the gap counter loaded to GAP-1.
  - `GAP=0` and FIFO non-empty: pop and go to ISSUE again (back-to-back).
  - Otherwise: go to IDLE.
- WAIT: `j=k=0`, counter decrements. When the counter is 0: pop and go to ISSUE if the FIFO is non-empty, else go to IDLE.

Shadow model:
- Updated on the edge that ends an ISSUE cycle.
- SET gives 1. CLR gives 0. TOGGLE gives `~shadow_q`. HOLD leaves it unchanged.
- TOGGLE or HOLD while `shadow_known=0` leaves `shadow_q` at 0 and `shadow_known` at 0, because the flip-flop has no reset and its `q` is unknown.

FIFO:
- Simultaneous push and pop leaves `count` unchanged.
- A push while full is impossible, because `cmd_ready=0`.
- A pop while empty never occurs.
- Pointers wrap modulo DEPTH.

## Timing
Reset values, all outputs after a `rst` edge:
- `j=0`, `k=0`, `issued=0`, `busy=0`, `count=0`, `shadow_q=0`, `shadow_known=0`.
- `cmd_ready=1`, state IDLE, FIFO flushed, gap counter 0.

Latency:
- A push at edge N into an empty, IDLE block is popped at edge N+1.
- `j`/`k`/`issued` are valid in the cycle between edges N+1 and N+2.
- The flip-flop samples at edge N+2, and `shadow_q` updates at that same edge.
- There is no bypass: the minimum push-to-drive latency is 1 cycle.

Throughput:
- One command every GAP+1 cycles.
- With GAP=0, one command per cycle while the FIFO is non-empty.

Reset mid-operation:
- Takes priority over every other event.
- An ISSUE cycle in progress at the reset edge is abandoned: `j`/`k` are 0 in the next cycle, and a push offered in the same cycle is dropped.

Simultaneous events:
- A push into an empty FIFO in the same cycle the FSM checks for work is not seen until the next edge.

## Structure
Shared package `jk_pkg`:
- Opcode typedef (`JK_HOLD`, `JK_SET`, `JK_CLR`, `JK_TOG`).
- FSM state typedef (`ST_IDLE`, `ST_ISSUE`, `ST_WAIT`).
- An opcode-to-`{j,k}` mapping function. `sr_flip_flop` users share the same encoding.

One sub-module, `jk_cmd_fifo`:
- Parameterised by DEPTH and data width.
- Ports: push, pop, din, dout, count, full, empty.
- Synchronous reset to empty.

## Test plan
- Reset, then a single push of SET at edge 1 (GAP=1): `j=1 k=0 issued=1` in cycle 2; `shadow_q=1` and `shadow_known=1` after edge 3; `busy=0` from cycle 4.
- DEPTH=4, `cmd_valid` held high with FSM stalled (GAP=15): `count` reaches 4 and `cmd_ready=0`; a 5th push is not accepted; draining restores `cmd_ready=1` after the first pop.
- GAP=0, push SET, TOG, TOG, CLR back-to-back: `j`/`k` go 10, 11, 11, 01 on consecutive cycles; `shadow_q` goes 1, 0, 1, 0.
- TOGGLE first after reset: `j=k=1` is issued, while `shadow_known` stays 0 and `shadow_q` stays 0; a following SET makes `shadow_known=1`.
- `rst` asserted during an ISSUE cycle with 3 entries queued: the next cycle shows `j=k=0`, `count=0`, `busy=0`, `cmd_ready=1`; no further `issued` pulses.
- Simultaneous push and pop at `count=2` leaves `count` at 2; after 20 mixed pushes/pops (DEPTH=4, pointer wrap), commands are issued in FIFO order.
